// File: rtl/tl45_lsu.sv
// tl45_lsu: single-outstanding load/store unit that turns core memory requests
// into classic pipelined Wishbone cycles and returns one tagged response each.
module tl45_lsu #(
   parameter int          AW      = 30,
   parameter int          DW      = 32,
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] ERR_VAL = 32'h1337_1337,
   localparam int         SW      = DW / 8,
   localparam int         OB      = $clog2(DW / 8)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_signed,
   input  logic [AW+OB-1:0]  i_req_addr,
   input  logic [DW-1:0]     i_req_wdata,
   input  logic [3:0]        i_req_dr,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [3:0]        o_rsp_dr,
   output logic [DW-1:0]     o_rsp_data,
   output logic [1:0]        o_rsp_err,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic              o_wb_we,
   output logic [AW-1:0]     o_wb_addr,
   output logic [DW-1:0]     o_wb_data,
   output logic [SW-1:0]     o_wb_sel,
   input  logic              i_wb_ack,
   input  logic              i_wb_stall,
   input  logic              i_wb_err,
   input  logic [DW-1:0]     i_wb_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, WAIT_ACK = 2'd2, RESP = 2'd3} state_t;

   localparam logic [DW-1:0] ERR_DW   = DW'(ERR_VAL);
   localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

   function automatic logic [SW-1:0] lane_mask(input logic [1:0] size, input logic [OB-1:0] off);
      return SW'(((32'd1 << (32'd1 << size)) - 32'd1) << off);
   endfunction

   function automatic logic [DW-1:0] rep_data(input logic [1:0] size, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      case (size)
         2'd0:    for (int i = 0; i < SW; i++)     r[8*i +: 8]   = d[7:0];
         2'd1:    for (int i = 0; i < SW / 2; i++) r[16*i +: 16] = d[15:0];
         2'd2:    for (int i = 0; i < SW / 4; i++) r[32*i +: 32] = d[31:0];
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] load_ext(input logic [1:0] size, input logic sgn,
                                              input logic [OB-1:0] off, input logic [DW-1:0] d);
      logic [DW-1:0] sh;
      logic [DW-1:0] r;
      logic          ext;
      int            nbits;
      sh    = d >> {off, 3'b000};
      nbits = 8 * int'(32'd1 << size);
      case (size)
         2'd0:    ext = sh[7];
         2'd1:    ext = sh[15];
         2'd2:    ext = sh[31];
         default: ext = sh[DW-1];
      endcase
      ext = ext & sgn;
      for (int i = 0; i < DW; i++) r[i] = (i < nbits) ? sh[i] : ext;
      return r;
   endfunction

   state_t          state_r, state_s;
   logic [15:0]     tmo_cnt_r, tmo_cnt_s;
   logic            we_r, signed_r;
   logic [1:0]      size_r;
   logic [OB-1:0]   off_r;
   logic [3:0]      dr_r;

   logic            cyc_s, stb_s, wbwe_s, rsp_valid_s, req_ready_s;
   logic [AW-1:0]   wbaddr_s;
   logic [DW-1:0]   wbdata_s, rsp_data_s, end_data_s;
   logic [SW-1:0]   sel_s;
   logic [3:0]      rsp_dr_s;
   logic [1:0]      rsp_err_s, end_err_s;
   logic            accept_s, bad_req_s, busy_s, bus_ok_s, fin_s, end_s;

   assign accept_s = i_req_valid && o_req_ready && !i_flush;
   assign busy_s   = (state_r == STROBE) || (state_r == WAIT_ACK);
   // Acks/errs only count once the strobe has actually been taken by the slave.
   assign bus_ok_s = (state_r == WAIT_ACK) || ((state_r == STROBE) && !i_wb_stall);
   assign fin_s    = bus_ok_s && (i_wb_ack || i_wb_err);
   assign end_s    = busy_s && (fin_s || (tmo_cnt_r == TMO_LAST));

   // Size/alignment legality of the offered request.
   always_comb begin
      if (int'(i_req_size) > OB) begin
         bad_req_s = 1'b1;
      end else if ((int'(i_req_addr[OB-1:0]) & (int'(32'd1 << i_req_size) - 32'sd1)) != 32'sd0) begin
         bad_req_s = 1'b1;
      end else begin
         bad_req_s = 1'b0;
      end
   end

   // Response code and data for a bus cycle that ends this cycle.
   always_comb begin
      if (fin_s && i_wb_err) begin
         end_err_s  = 2'd1;
         end_data_s = ERR_DW;
      end else if (fin_s) begin
         end_err_s  = 2'd0;
         end_data_s = we_r ? {DW{1'b0}} : load_ext(size_r, signed_r, off_r, i_wb_data);
      end else begin
         end_err_s  = 2'd2;
         end_data_s = ERR_DW;
      end
   end

   // Next state and next values of all registered outputs.
   always_comb begin
      state_s     = state_r;
      tmo_cnt_s   = tmo_cnt_r;
      cyc_s       = o_wb_cyc;
      stb_s       = o_wb_stb;
      wbwe_s      = o_wb_we;
      wbaddr_s    = o_wb_addr;
      wbdata_s    = o_wb_data;
      sel_s       = o_wb_sel;
      rsp_valid_s = o_rsp_valid;
      rsp_dr_s    = o_rsp_dr;
      rsp_data_s  = o_rsp_data;
      rsp_err_s   = o_rsp_err;
      if (i_flush) begin
         state_s     = IDLE;
         cyc_s       = 1'b0;
         stb_s       = 1'b0;
         rsp_valid_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && bad_req_s) begin
                  state_s     = RESP;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 2'd3;
                  rsp_data_s  = ERR_DW;
                  rsp_dr_s    = i_req_we ? 4'd0 : i_req_dr;
               end else if (accept_s) begin
                  state_s   = STROBE;
                  tmo_cnt_s = 16'd0;
                  cyc_s     = 1'b1;
                  stb_s     = 1'b1;
                  wbwe_s    = i_req_we;
                  wbaddr_s  = i_req_addr[AW+OB-1:OB];
                  wbdata_s  = rep_data(i_req_size, i_req_wdata);
                  sel_s     = lane_mask(i_req_size, i_req_addr[OB-1:0]);
               end else begin
                  state_s = IDLE;
               end
            end
            STROBE, WAIT_ACK: begin
               tmo_cnt_s = tmo_cnt_r + 16'd1;
               if (end_s) begin
                  state_s     = RESP;
                  cyc_s       = 1'b0;
                  stb_s       = 1'b0;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = end_err_s;
                  rsp_data_s  = end_data_s;
                  rsp_dr_s    = we_r ? 4'd0 : dr_r;
               end else if ((state_r == STROBE) && !i_wb_stall) begin
                  state_s = WAIT_ACK;
                  stb_s   = 1'b0;
               end else begin
                  state_s = state_r;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  state_s     = IDLE;
                  rsp_valid_s = 1'b0;
               end else begin
                  state_s = RESP;
               end
            end
            default: begin
               state_s = IDLE;
               cyc_s   = 1'b0;
               stb_s   = 1'b0;
            end
         endcase
      end
      req_ready_s = (state_s == IDLE);
   end

   // State, output and request-field registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= IDLE;
         tmo_cnt_r   <= 16'd0;
         o_req_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_dr    <= 4'd0;
         o_rsp_data  <= {DW{1'b0}};
         o_rsp_err   <= 2'd0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_addr   <= {AW{1'b0}};
         o_wb_data   <= {DW{1'b0}};
         o_wb_sel    <= {SW{1'b0}};
         we_r        <= 1'b0;
         signed_r    <= 1'b0;
         size_r      <= 2'd0;
         off_r       <= {OB{1'b0}};
         dr_r        <= 4'd0;
      end else begin
         state_r     <= state_s;
         tmo_cnt_r   <= tmo_cnt_s;
         o_req_ready <= req_ready_s;
         o_rsp_valid <= rsp_valid_s;
         o_rsp_dr    <= rsp_dr_s;
         o_rsp_data  <= rsp_data_s;
         o_rsp_err   <= rsp_err_s;
         o_wb_cyc    <= cyc_s;
         o_wb_stb    <= stb_s;
         o_wb_we     <= wbwe_s;
         o_wb_addr   <= wbaddr_s;
         o_wb_data   <= wbdata_s;
         o_wb_sel    <= sel_s;
         if (accept_s) begin
            we_r     <= i_req_we;
            signed_r <= i_req_signed;
            size_r   <= i_req_size;
            off_r    <= i_req_addr[OB-1:0];
            dr_r     <= i_req_dr;
         end
      end
   end

endmodule

// File: tb/tb_tl45_lsu.sv
// Directed self-checking bench for tl45_lsu (32-bit data, TIMEOUT=4) with
// hand-driven Wishbone slave responses.
module tb_tl45_lsu;

   logic        i_clk, i_reset, i_flush;
   logic        i_req_valid, o_req_ready, i_req_we, i_req_signed;
   logic [1:0]  i_req_size;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [3:0]  i_req_dr;
   logic        o_rsp_valid, i_rsp_ready;
   logic [3:0]  o_rsp_dr;
   logic [31:0] o_rsp_data;
   logic [1:0]  o_rsp_err;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [29:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_ack, i_wb_stall, i_wb_err;
   logic [31:0] i_wb_data;

   int errors = 0;
   int checks = 0;
   int n;

   tl45_lsu #(.AW(30), .DW(32), .TIMEOUT(4), .ERR_VAL(32'h1337_1337)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_size(i_req_size), .i_req_signed(i_req_signed), .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata), .i_req_dr(i_req_dr),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dr(o_rsp_dr),
      .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack),
      .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] dr);
      i_req_valid  = 1'b1;
      i_req_we     = we;
      i_req_size   = size;
      i_req_signed = sgn;
      i_req_addr   = addr;
      i_req_wdata  = wdata;
      i_req_dr     = dr;
      step();
      i_req_valid  = 1'b0;
   endtask

   task automatic drain();
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      chk("drain_rsp_valid", o_rsp_valid, 1'b0);
      chk("drain_req_ready", o_req_ready, 1'b1);
   endtask

   initial begin
      i_reset = 1'b1; i_flush = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
      i_req_size = 2'd0; i_req_signed = 1'b0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
      i_req_dr = 4'd0; i_rsp_ready = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0;
      i_wb_err = 1'b0; i_wb_data = 32'd0;
      step(); step();
      chk("rst_req_ready", o_req_ready, 1'b1);
      chk("rst_rsp_valid", o_rsp_valid, 1'b0);
      chk("rst_cyc", o_wb_cyc, 1'b0);
      chk("rst_stb", o_wb_stb, 1'b0);
      chk("rst_rsp_data", o_rsp_data, 32'd0);
      i_reset = 1'b0;

      // signed byte load at 0x103, ack in the cycle after the strobe
      req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 4'd5);
      chk("t1_cyc", o_wb_cyc, 1'b1);
      chk("t1_stb", o_wb_stb, 1'b1);
      chk("t1_sel", o_wb_sel, 4'b1000);
      chk("t1_addr", o_wb_addr, 30'h40);
      chk("t1_we", o_wb_we, 1'b0);
      chk("t1_ready_busy", o_req_ready, 1'b0);
      step();
      chk("t1_stb_drop", o_wb_stb, 1'b0);
      chk("t1_cyc_hold", o_wb_cyc, 1'b1);
      i_wb_ack = 1'b1; i_wb_data = 32'h80FF_1234;
      step();
      i_wb_ack = 1'b0;
      chk("t1_rsp_valid", o_rsp_valid, 1'b1);
      chk("t1_rsp_data", o_rsp_data, 32'hFFFF_FF80);
      chk("t1_rsp_err", o_rsp_err, 2'd0);
      chk("t1_rsp_dr", o_rsp_dr, 4'd5);
      chk("t1_cyc_low", o_wb_cyc, 1'b0);
      drain();

      // unsigned halfword load, same-cycle ack: minimum latency
      req(1'b0, 2'd1, 1'b0, 32'h6, 32'd0, 4'd3);
      chk("t2_sel", o_wb_sel, 4'b1100);
      chk("t2_addr", o_wb_addr, 30'h1);
      i_wb_ack = 1'b1; i_wb_data = 32'h8001_5A5A;
      step();
      i_wb_ack = 1'b0;
      chk("t2_rsp_valid", o_rsp_valid, 1'b1);
      chk("t2_rsp_data", o_rsp_data, 32'h0000_8001);
      chk("t2_cyc_low", o_wb_cyc, 1'b0);
      drain();

      // halfword store with 3 stalled strobe cycles; ack during stall is ignored
      req(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 4'd7);
      chk("t3_sel", o_wb_sel, 4'b1100);
      chk("t3_addr", o_wb_addr, 30'h80);
      chk("t3_we", o_wb_we, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("t3_stb_held", o_wb_stb, 1'b1);
         chk("t3_wdata", o_wb_data, 32'hABCD_ABCD);
         i_wb_stall = (k < 3);
         i_wb_ack   = (k == 1) || (k == 3);
         step();
      end
      i_wb_stall = 1'b0; i_wb_ack = 1'b0;
      chk("t3_stb_low", o_wb_stb, 1'b0);
      chk("t3_cyc_low", o_wb_cyc, 1'b0);
      chk("t3_rsp_valid", o_rsp_valid, 1'b1);
      chk("t3_rsp_err", o_rsp_err, 2'd0);
      chk("t3_rsp_dr", o_rsp_dr, 4'd0);
      chk("t3_rsp_data", o_rsp_data, 32'd0);
      drain();

      // misaligned word load, response held 5 cycles
      req(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 4'd9);
      chk("t4_rsp_valid", o_rsp_valid, 1'b1);
      chk("t4_rsp_err", o_rsp_err, 2'd3);
      chk("t4_rsp_data", o_rsp_data, 32'h1337_1337);
      chk("t4_rsp_dr", o_rsp_dr, 4'd9);
      chk("t4_no_cyc", o_wb_cyc, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t4_hold_valid", o_rsp_valid, 1'b1);
         chk("t4_hold_data", o_rsp_data, 32'h1337_1337);
         chk("t4_hold_err", o_rsp_err, 2'd3);
         chk("t4_hold_dr", o_rsp_dr, 4'd9);
         chk("t4_hold_ready", o_req_ready, 1'b0);
         chk("t4_hold_no_cyc", o_wb_cyc, 1'b0);
      end
      drain();

      // 8-byte access on a 4-byte bus is unsupported
      req(1'b0, 2'd3, 1'b0, 32'h8, 32'd0, 4'd2);
      chk("t4b_rsp_err", o_rsp_err, 2'd3);
      chk("t4b_no_cyc", o_wb_cyc, 1'b0);
      drain();

      // slave never answers: cyc high exactly TIMEOUT cycles
      req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 4'd4);
      n = 0;
      while (o_wb_cyc && n < 20) begin
         n++;
         step();
      end
      chk("t5_cyc_cycles", n, 4);
      chk("t5_rsp_valid", o_rsp_valid, 1'b1);
      chk("t5_rsp_err", o_rsp_err, 2'd2);
      chk("t5_rsp_data", o_rsp_data, 32'h1337_1337);
      drain();

      // bus error together with ack on a load
      req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 4'd6);
      i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_data = 32'h5555_5555;
      step();
      i_wb_ack = 1'b0; i_wb_err = 1'b0;
      chk("t6_rsp_err", o_rsp_err, 2'd1);
      chk("t6_rsp_data", o_rsp_data, 32'h1337_1337);
      chk("t6_rsp_dr", o_rsp_dr, 4'd6);
      chk("t6_cyc_low", o_wb_cyc, 1'b0);
      drain();

      // flush during WAIT_ACK, late ack afterwards
      req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 4'd1);
      step();
      chk("t7_wait_cyc", o_wb_cyc, 1'b1);
      i_flush = 1'b1;
      step();
      i_flush = 1'b0; i_wb_ack = 1'b1;
      chk("t7_cyc_low", o_wb_cyc, 1'b0);
      chk("t7_no_rsp", o_rsp_valid, 1'b0);
      chk("t7_ready", o_req_ready, 1'b1);
      step();
      i_wb_ack = 1'b0;
      chk("t7_late_ack_no_rsp", o_rsp_valid, 1'b0);
      chk("t7_late_ack_no_cyc", o_wb_cyc, 1'b0);

      // flush and ack in the same cycle: flush wins
      req(1'b0, 2'd2, 1'b0, 32'h34, 32'd0, 4'd1);
      i_flush = 1'b1; i_wb_ack = 1'b1;
      step();
      i_flush = 1'b0; i_wb_ack = 1'b0;
      chk("t8_no_rsp", o_rsp_valid, 1'b0);
      chk("t8_cyc_low", o_wb_cyc, 1'b0);
      chk("t8_ready", o_req_ready, 1'b1);

      // request offered together with flush is not accepted
      i_flush = 1'b1;
      req(1'b0, 2'd2, 1'b0, 32'h38, 32'd0, 4'd1);
      i_flush = 1'b0;
      chk("t9_no_cyc", o_wb_cyc, 1'b0);
      chk("t9_no_rsp", o_rsp_valid, 1'b0);
      chk("t9_ready", o_req_ready, 1'b1);

      // reset in the middle of a stalled strobe
      req(1'b1, 2'd2, 1'b0, 32'h44, 32'hDEAD_BEEF, 4'd0);
      i_wb_stall = 1'b1;
      chk("t10_wdata", o_wb_data, 32'hDEAD_BEEF);
      chk("t10_sel", o_wb_sel, 4'b1111);
      chk("t10_addr", o_wb_addr, 30'h11);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0; i_wb_stall = 1'b0;
      chk("t10_cyc", o_wb_cyc, 1'b0);
      chk("t10_stb", o_wb_stb, 1'b0);
      chk("t10_we", o_wb_we, 1'b0);
      chk("t10_addr_rst", o_wb_addr, 30'h0);
      chk("t10_data_rst", o_wb_data, 32'h0);
      chk("t10_sel_rst", o_wb_sel, 4'h0);
      chk("t10_ready", o_req_ready, 1'b1);
      chk("t10_rsp_valid", o_rsp_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
